qracc_sram_arbiter: RTL and testbench
=====================================

# qracc_sram_arbiter

Parametrised N-master arbiter for the accelerator's SRAM request/response handshake (write-or-read request with valid/ready, read data returned later with its own valid). It lets several requesters (weight loader, activation path, debug/CSR readback) share one SRAM bank controller. It supports round-robin or fixed-priority arbitration and any master count. An in-order tag FIFO routes each read response back to the master that issued it.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters (≥2)
- NUM_ROWS, 128, SRAM rows; ADDR_W = $clog2(NUM_ROWS)
- NUM_COLS, 32, data word width
- RD_DEPTH, 4, maximum outstanding reads (tag FIFO depth, ≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- arb_mode_i  input  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- m_rq_valid_i  input  NUM_MASTERS  per-master request valid
- m_rq_wr_i  input  NUM_MASTERS  per-master 1 = write, 0 = read
- m_addr_i  input  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wr_data_i  input  NUM_MASTERS*NUM_COLS  packed write data
- m_rq_ready_o  output  NUM_MASTERS  per-master request accepted
- m_rd_valid_o  output  NUM_MASTERS  one-hot read-response valid
- m_rd_data_o  output  NUM_COLS  read data, broadcast to all masters
- s_rq_valid_o  output  1  request to SRAM controller
- s_rq_wr_o  output  1  write/read to SRAM controller
- s_addr_o  output  ADDR_W  address to SRAM controller
- s_wr_data_o  output  NUM_COLS  write data to SRAM controller
- s_rq_ready_i  input  1  SRAM controller accepts request
- s_rd_valid_i  input  1  SRAM read data valid
- s_rd_data_i  input  NUM_COLS  SRAM read data
- rd_pending_o  output  $clog2(RD_DEPTH+1)  outstanding read count
- err_o  output  1  sticky: read response arrived with no outstanding read

## Operation
- Eligibility: master i is eligible when m_rq_valid_i[i] is high and either m_rq_wr_i[i] = 1 or the tag FIFO is not full.
- Grant g is combinational over eligible masters:
  - Round-robin: first eligible index searching ptr, ptr+1, … modulo NUM_MASTERS.
  - Fixed priority: lowest eligible index; ptr is ignored and held.
- The arbiter drives s_rq_valid_o = any eligible. s_rq_wr_o, s_addr_o and s_wr_data_o are muxed from g. When nothing is eligible, these are 0.
- m_rq_ready_o[g] = s_rq_ready_i. All other ready bits are 0.
- Handshake happens when s_rq_valid_o and s_rq_ready_i are both high.
  - In round-robin mode, ptr <= (g+1) mod NUM_MASTERS.
  - If the request is a read, the index g is pushed into the tag FIFO.
- Response: when s_rd_valid_i is high and the FIFO is non-empty, m_rd_valid_o[head] = 1 and the head is popped. m_rd_data_o = s_rd_data_i always (pass-through).
- When s_rd_valid_i is high and the FIFO is empty, m_rd_valid_o stays all 0 and err_o sets. err_o clears only on reset.
- A push and a pop in the same cycle leave the count unchanged and are both legal. The full check uses the registered count only, so a read is blocked whenever the FIFO is full, even if a pop happens that cycle.
- arb_mode_i may change at any cycle and takes effect combinationally. ptr keeps its value across mode changes.
- The SRAM controller must return reads in order.

## Timing
- Request path is zero-cycle combinational, master to SRAM controller; there is no added latency.
- Response path is zero-cycle combinational, s_rd_valid_i to m_rd_valid_o.
- FIFO pointers, count, ptr and err_o update on the rising clk edge.
- Reset values:
  - ptr = 0, FIFO empty, rd_pending_o = 0, err_o = 0.
  - All outputs are 0, except m_rd_data_o, which follows s_rd_data_i.
- Reset mid-operation: outstanding tags are discarded. A late response after reset has no tag, so it is not routed and it sets err_o.
- Boundary conditions:
  - rd_pending_o = RD_DEPTH: only writes can be granted.
  - ptr at NUM_MASTERS-1 wraps to 0.
  - A single requesting master is granted every cycle that s_rq_ready_i is high.

## Test plan
- Round-robin fairness: NUM_MASTERS=4, all four issue continuous writes, s_rq_ready_i=1 → grants 0,1,2,3,0,… one per cycle, with s_addr_o matching each master.
- Fixed priority: arb_mode_i=1, masters 1 and 3 both valid for 3 cycles → master 1 is granted all 3 cycles and master 3 is starved; then drop master 1 → master 3 is granted next cycle.
- Read routing: master 2 reads addr 5, then master 0 reads addr 9; the SRAM controller returns 0xAAAA, then 0xBBBB, 2 cycles later → m_rd_valid_o = 4'b0100 with 0xAAAA, then 4'b0001 with 0xBBBB; rd_pending_o goes 1, 2, 1, 0.
- Full FIFO: RD_DEPTH=4, 4 reads outstanding, master 0 read + master 1 write pending → master 1 write is granted and master 0 is not; after one response, master 0 is granted the next cycle.
- Backpressure: s_rq_ready_i=0 for 5 cycles with requests pending → no ready, ptr unchanged, s_rq_valid_o held high; the first grant after ready rises matches the pre-stall ptr.
- Spurious response and reset: pulse s_rd_valid_i with the FIFO empty → err_o=1, no m_rd_valid_o; assert nrst with 2 reads outstanding → rd_pending_o=0, err_o=0 immediately.

Source files
------------

// File: rtl/qracc_sram_arbiter.sv
// N-master arbiter in front of one SRAM bank controller. Requests are granted round-robin
// or by fixed priority, and an in-order tag FIFO sends each read response to its requester.
module qracc_sram_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_ROWS    = 128,
  parameter int NUM_COLS    = 32,
  parameter int RD_DEPTH    = 4,
  localparam int ADDR_W     = $clog2(NUM_ROWS),
  localparam int CNT_W      = $clog2(RD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          arb_mode_i,
  input  logic [NUM_MASTERS-1:0]        m_rq_valid_i,
  input  logic [NUM_MASTERS-1:0]        m_rq_wr_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*NUM_COLS-1:0] m_wr_data_i,
  output logic [NUM_MASTERS-1:0]        m_rq_ready_o,
  output logic [NUM_MASTERS-1:0]        m_rd_valid_o,
  output logic [NUM_COLS-1:0]           m_rd_data_o,
  output logic                          s_rq_valid_o,
  output logic                          s_rq_wr_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [NUM_COLS-1:0]           s_wr_data_o,
  input  logic                          s_rq_ready_i,
  input  logic                          s_rd_valid_i,
  input  logic [NUM_COLS-1:0]           s_rd_data_i,
  output logic [CNT_W-1:0]              rd_pending_o,
  output logic                          err_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       tag_mem [RD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   any_eligible;
  logic                   grant_hit;
  logic [IDX_W-1:0]       grant_idx;
  logic                   handshake;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] fifo_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full is judged on the registered count alone, so a same-cycle pop never unblocks a read.
  assign fifo_full    = (count == CNT_W'(RD_DEPTH));
  assign fifo_empty   = (count == '0);
  assign eligible     = m_rq_valid_i & (m_rq_wr_i | {NUM_MASTERS{~fifo_full}});
  assign any_eligible = |eligible;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    if (arb_mode_i) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!grant_hit && eligible[i]) begin
          grant_hit = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!grant_hit && eligible[(int'(rr_ptr) + k) % NUM_MASTERS]) begin
          grant_hit = 1'b1;
          grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
        end
      end
    end
  end

  always_comb begin
    s_rq_valid_o = any_eligible;
    s_rq_wr_o    = 1'b0;
    s_addr_o     = '0;
    s_wr_data_o  = '0;
    m_rq_ready_o = '0;
    if (any_eligible) begin
      s_rq_wr_o               = m_rq_wr_i[grant_idx];
      s_addr_o                = m_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
      s_wr_data_o             = m_wr_data_i[int'(grant_idx)*NUM_COLS +: NUM_COLS];
      m_rq_ready_o[grant_idx] = s_rq_ready_i;
    end
  end

  assign handshake = any_eligible & s_rq_ready_i;
  assign push      = handshake & ~s_rq_wr_o;
  assign pop       = s_rd_valid_i & ~fifo_empty;

  always_comb begin
    m_rd_valid_o = '0;
    if (pop) m_rd_valid_o[tag_mem[rd_ptr]] = 1'b1;
  end

  assign m_rd_data_o  = s_rd_data_i;
  assign rd_pending_o = count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (handshake && !arb_mode_i) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= fifo_next(wr_ptr);
      if (pop)  rd_ptr <= fifo_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Tag storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_o <= 1'b0;
    end else if (s_rd_valid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed, table-driven bench for qracc_sram_arbiter with 4 masters and a 4-deep tag FIFO.
module tb_qracc_sram_arbiter;

  localparam int NM = 4;
  localparam int AW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            arb_mode_i;
  logic [NM-1:0]   m_rq_valid_i;
  logic [NM-1:0]   m_rq_wr_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_wr_data_i;
  logic [NM-1:0]   m_rq_ready_o;
  logic [NM-1:0]   m_rd_valid_o;
  logic [DW-1:0]   m_rd_data_o;
  logic            s_rq_valid_o;
  logic            s_rq_wr_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wr_data_o;
  logic            s_rq_ready_i;
  logic            s_rd_valid_i;
  logic [DW-1:0]   s_rd_data_i;
  logic [2:0]      rd_pending_o;
  logic            err_o;

  qracc_sram_arbiter dut (
    .clk(clk), .nrst(nrst), .arb_mode_i(arb_mode_i),
    .m_rq_valid_i(m_rq_valid_i), .m_rq_wr_i(m_rq_wr_i),
    .m_addr_i(m_addr_i), .m_wr_data_i(m_wr_data_i),
    .m_rq_ready_o(m_rq_ready_o), .m_rd_valid_o(m_rd_valid_o), .m_rd_data_o(m_rd_data_o),
    .s_rq_valid_o(s_rq_valid_o), .s_rq_wr_o(s_rq_wr_o), .s_addr_o(s_addr_o),
    .s_wr_data_o(s_wr_data_o), .s_rq_ready_i(s_rq_ready_i), .s_rd_valid_i(s_rd_valid_i),
    .s_rd_data_i(s_rd_data_i), .rd_pending_o(rd_pending_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  valid;
    logic [3:0]  wr;
    logic        s_ready;
    logic        s_rd_valid;
    logic [31:0] rd_data;
    int          gnt;
    logic        exp_wr;
    logic [3:0]  exp_rd_valid;
    int          exp_pending;
    logic        exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];
  logic [AW-1:0] addr_tab [NM];
  logic [DW-1:0] wdata_tab [NM];

  function automatic vec_t mkv(input logic mode, input logic [3:0] valid, input logic [3:0] wr,
                               input logic s_ready, input logic s_rd_valid, input logic [31:0] rd_data,
                               input int gnt, input logic exp_wr, input logic [3:0] exp_rd_valid,
                               input int exp_pending, input logic exp_err);
    vec_t v;
    v.mode = mode; v.valid = valid; v.wr = wr; v.s_ready = s_ready;
    v.s_rd_valid = s_rd_valid; v.rd_data = rd_data; v.gnt = gnt; v.exp_wr = exp_wr;
    v.exp_rd_valid = exp_rd_valid; v.exp_pending = exp_pending; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    arb_mode_i   = v.mode;
    m_rq_valid_i = v.valid;
    m_rq_wr_i    = v.wr;
    s_rq_ready_i = v.s_ready;
    s_rd_valid_i = v.s_rd_valid;
    s_rd_data_i  = v.rd_data;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    logic [3:0]  exp_ready;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    exp_ready = '0;
    exp_addr  = '0;
    exp_wdata = '0;
    if (v.gnt >= 0) begin
      if (v.s_ready) exp_ready[v.gnt] = 1'b1;
      exp_addr  = 32'(addr_tab[v.gnt]);
      exp_wdata = wdata_tab[v.gnt];
    end
    checkOutput($sformatf("v%0d.s_valid", idx), 32'(s_rq_valid_o), 32'(v.gnt >= 0));
    checkOutput($sformatf("v%0d.ready", idx), 32'(m_rq_ready_o), 32'(exp_ready));
    checkOutput($sformatf("v%0d.addr", idx), 32'(s_addr_o), exp_addr);
    checkOutput($sformatf("v%0d.wdata", idx), s_wr_data_o, exp_wdata);
    checkOutput($sformatf("v%0d.s_wr", idx), 32'(s_rq_wr_o), 32'(v.exp_wr));
    checkOutput($sformatf("v%0d.rd_valid", idx), 32'(m_rd_valid_o), 32'(v.exp_rd_valid));
    checkOutput($sformatf("v%0d.rd_data", idx), m_rd_data_o, v.rd_data);
    checkOutput($sformatf("v%0d.pending", idx), 32'(rd_pending_o), 32'(v.exp_pending));
    checkOutput($sformatf("v%0d.err", idx), 32'(err_o), 32'(v.exp_err));
  endtask

  initial begin
    addr_tab[0] = 7'd9;  addr_tab[1] = 7'd17; addr_tab[2] = 7'd5; addr_tab[3] = 7'd33;
    for (int i = 0; i < NM; i++) begin
      wdata_tab[i] = 32'h1000 + 32'(i);
      m_addr_i[i*AW +: AW]    = addr_tab[i];
      m_wr_data_i[i*DW +: DW] = wdata_tab[i];
    end

    // round-robin writes from all four masters
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 4'hF, 4'hF, 1, 0, 32'hC3, i % 4, 1, 4'h0, 0, 0));
    // backpressure: ptr sits at 1 while ready is low
    for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 4'hF, 4'hF, 0, 0, 32'hC3, 1, 1, 4'h0, 0, 0));
    vecs.push_back(mkv(0, 4'hF, 4'hF, 1, 0, 32'hC3, 1, 1, 4'h0, 0, 0));
    // fixed priority: master 1 starves master 3, ptr (2) held for the switch back
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(1, 4'b1010, 4'b1010, 1, 0, 32'hC3, 1, 1, 4'h0, 0, 0));
    vecs.push_back(mkv(1, 4'b1000, 4'b1000, 1, 0, 32'hC3, 3, 1, 4'h0, 0, 0));
    vecs.push_back(mkv(0, 4'hF, 4'hF, 0, 0, 32'hC3, 2, 1, 4'h0, 0, 0));
    // read routing: master 2 then master 0, responses in order
    vecs.push_back(mkv(0, 4'b0100, 4'b0000, 1, 0, 32'hC3, 2, 0, 4'h0, 0, 0));
    vecs.push_back(mkv(0, 4'b0001, 4'b0000, 1, 0, 32'hC3, 0, 0, 4'h0, 1, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 0, 32'hC3, -1, 0, 4'h0, 2, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 0, 32'hC3, -1, 0, 4'h0, 2, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 1, 32'hAAAA, -1, 0, 4'b0100, 2, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 1, 32'hBBBB, -1, 0, 4'b0001, 1, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 0, 32'hC3, -1, 0, 4'h0, 0, 0));
    // fill the tag FIFO, then read blocked while a write gets through
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(1, 4'b0001, 4'b0000, 1, 0, 32'hC3, 0, 0, 4'h0, i, 0));
    vecs.push_back(mkv(1, 4'b0011, 4'b0010, 1, 0, 32'hC3, 1, 1, 4'h0, 4, 0));
    vecs.push_back(mkv(1, 4'b0011, 4'b0010, 1, 1, 32'h1234, 1, 1, 4'b0001, 4, 0));
    vecs.push_back(mkv(1, 4'b0011, 4'b0010, 1, 0, 32'hC3, 0, 0, 4'h0, 3, 0));
    vecs.push_back(mkv(1, 4'h0, 4'h0, 0, 1, 32'h5678, -1, 0, 4'b0001, 4, 0));
    vecs.push_back(mkv(1, 4'b0001, 4'b0000, 1, 1, 32'h9ABC, 0, 0, 4'b0001, 3, 0));
    for (int i = 3; i > 0; i--) vecs.push_back(mkv(1, 4'h0, 4'h0, 0, 1, 32'h4000 + 32'(i), -1, 0, 4'b0001, i, 0));
    vecs.push_back(mkv(1, 4'h0, 4'h0, 0, 0, 32'hC3, -1, 0, 4'h0, 0, 0));
    // spurious response with an empty FIFO
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 1, 32'hEEEE, -1, 0, 4'h0, 0, 0));
    vecs.push_back(mkv(0, 4'h0, 4'h0, 0, 0, 32'hC3, -1, 0, 4'h0, 0, 1));
    // lone master 3 granted every cycle, ptr wraps to 0
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(0, 4'b1000, 4'b1000, 1, 0, 32'hC3, 3, 1, 4'h0, 0, 1));
    vecs.push_back(mkv(0, 4'hF, 4'hF, 0, 0, 32'hC3, 0, 1, 4'h0, 0, 1));

    nrst = 1'b0;
    arb_mode_i = 1'b0; m_rq_valid_i = '0; m_rq_wr_i = '0;
    s_rq_ready_i = 1'b0; s_rd_valid_i = 1'b0; s_rd_data_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.s_valid", 32'(s_rq_valid_o), 32'h0);
    checkOutput("reset.ready", 32'(m_rq_ready_o), 32'h0);
    checkOutput("reset.rd_valid", 32'(m_rd_valid_o), 32'h0);
    checkOutput("reset.pending", 32'(rd_pending_o), 32'h0);
    checkOutput("reset.err", 32'(err_o), 32'h0);
    nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // two reads from master 2, then asynchronous reset mid-cycle
    @(negedge clk);
    arb_mode_i = 1'b0; m_rq_valid_i = 4'b0100; m_rq_wr_i = 4'b0000;
    s_rq_ready_i = 1'b1; s_rd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    m_rq_valid_i = '0; s_rq_ready_i = 1'b0;
    #1;
    checkOutput("rst_seq.pending_before", 32'(rd_pending_o), 32'h2);
    checkOutput("rst_seq.err_before", 32'(err_o), 32'h1);
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst_seq.pending_async", 32'(rd_pending_o), 32'h0);
    checkOutput("rst_seq.err_async", 32'(err_o), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    s_rd_valid_i = 1'b1; s_rd_data_i = 32'h77;
    #1;
    checkOutput("rst_seq.late_rd_valid", 32'(m_rd_valid_o), 32'h0);
    checkOutput("rst_seq.late_err_pre", 32'(err_o), 32'h0);
    @(negedge clk);
    s_rd_valid_i = 1'b0;
    #1;
    checkOutput("rst_seq.late_err", 32'(err_o), 32'h1);
    checkOutput("rst_seq.late_pending", 32'(rd_pending_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
